// File: rtl/zion_bc_skid_pkg.sv
// Shared types and encodings for the two-entry skid buffer and its register stages.
package zion_bc_skid_pkg;

  localparam logic [1:0] EncEmpty = 2'd0;
  localparam logic [1:0] EncOne   = 2'd1;
  localparam logic [1:0] EncFull  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = EncEmpty,
    ONE   = EncOne,
    FULL  = EncFull
  } skid_state_t;

  // Reset configuration codes understood by ZionBasicCircuitLib_ClrEnRcDff.
  localparam int unsigned RstCfgAsyncLow  = 0;
  localparam int unsigned RstCfgAsyncHigh = 1;
  localparam int unsigned RstCfgSyncLow   = 2;
  localparam int unsigned RstCfgSyncHigh  = 3;

endpackage

// File: rtl/ZionBasicCircuitLib_ClrEnRcDff.sv
// Data register with selectable reset style, synchronous clear and load enable.
// Priority: reset > clear > enable; reset and clear both load INI_DATA.
module ZionBasicCircuitLib_ClrEnRcDff
  import zion_bc_skid_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       RST_CFG  = RstCfgSyncHigh,
  parameter logic [WIDTH-1:0]  INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iDat,
  output logic [WIDTH-1:0] oDat
);

  logic [WIDTH-1:0] datD;
  logic [WIDTH-1:0] datQ;

  always_comb begin
    datD = datQ;
    if (iClr) begin
      datD = INI_DATA;
    end else if (iEn) begin
      datD = iDat;
    end
  end

  generate
    if (RST_CFG == RstCfgAsyncLow) begin : gAsyncLow
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) datQ <= INI_DATA;
        else      datQ <= datD;
      end
    end else if (RST_CFG == RstCfgAsyncHigh) begin : gAsyncHigh
      always_ff @(posedge clk or posedge rst) begin
        if (rst) datQ <= INI_DATA;
        else     datQ <= datD;
      end
    end else if (RST_CFG == RstCfgSyncLow) begin : gSyncLow
      always_ff @(posedge clk) begin
        if (!rst) datQ <= INI_DATA;
        else      datQ <= datD;
      end
    end else begin : gSyncHigh
      always_ff @(posedge clk) begin
        if (rst) datQ <= INI_DATA;
        else     datQ <= datD;
      end
    end
  endgenerate

  assign oDat = datQ;

endmodule

// File: rtl/zion_bc_skid_buffer.sv
// Two-entry valid/ready register slice; all outputs registered, no iRdy->oRdy path.
// Main register drives oDat, skid register absorbs one beat under back-pressure.
module zion_bc_skid_buffer
  import zion_bc_skid_pkg::*;
#(
  parameter int unsigned          WIDTH_IN  = 32,
  parameter int unsigned          WIDTH_OUT = 32,
  parameter logic [WIDTH_OUT-1:0] INI_DATA  = WIDTH_OUT'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iClr,
  input  logic                 iVld,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oRdy,
  output logic                 oVld,
  output logic [WIDTH_OUT-1:0] oDat,
  input  logic                 iRdy
);

  skid_state_t          stateQ, stateD;
  logic                 vldQ, vldD;
  logic                 rdyQ, rdyD;
  logic                 accept, pop;
  logic                 loadMain, loadSkid, selSkid;
  logic [WIDTH_OUT-1:0] datIn;
  logic [WIDTH_OUT-1:0] mainD;
  logic [WIDTH_OUT-1:0] skidDat;

  // Zero-extend or keep the LSBs of the upstream word.
  generate
    if (WIDTH_OUT > WIDTH_IN) begin : gExtend
      assign datIn = {{(WIDTH_OUT - WIDTH_IN){1'b0}}, iDat};
    end else if (WIDTH_OUT < WIDTH_IN) begin : gTruncate
      logic unusedHi;
      assign unusedHi = ^iDat[WIDTH_IN-1:WIDTH_OUT];
      assign datIn    = iDat[WIDTH_OUT-1:0];
    end else begin : gPass
      assign datIn = iDat;
    end
  endgenerate

  assign accept = iVld & rdyQ;
  assign pop    = vldQ & iRdy;

  always_comb begin
    stateD   = stateQ;
    loadMain = 1'b0;
    loadSkid = 1'b0;
    selSkid  = 1'b0;
    unique case (stateQ)
      EMPTY: begin
        if (accept) begin
          stateD   = ONE;
          loadMain = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          loadMain = 1'b1;
        end else if (accept) begin
          stateD   = FULL;
          loadSkid = 1'b1;
        end else if (pop) begin
          stateD = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          stateD   = ONE;
          loadMain = 1'b1;
          selSkid  = 1'b1;
        end
      end
      default: stateD = EMPTY;
    endcase
    // Clear discards any accepted beat; the data registers handle their own clear.
    if (iClr) begin
      stateD = EMPTY;
    end
    vldD = (stateD != EMPTY);
    rdyD = (stateD != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= EMPTY;
      vldQ   <= 1'b0;
      rdyQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      vldQ   <= vldD;
      rdyQ   <= rdyD;
    end
  end

  assign mainD = selSkid ? skidDat : datIn;

  ZionBasicCircuitLib_ClrEnRcDff #(
    .WIDTH    (WIDTH_OUT),
    .RST_CFG  (RstCfgSyncHigh),
    .INI_DATA (INI_DATA)
  ) uMainDff (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iEn  (loadMain),
    .iDat (mainD),
    .oDat (oDat)
  );

  ZionBasicCircuitLib_ClrEnRcDff #(
    .WIDTH    (WIDTH_OUT),
    .RST_CFG  (RstCfgSyncHigh),
    .INI_DATA (INI_DATA)
  ) uSkidDff (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iEn  (loadSkid),
    .iDat (datIn),
    .oDat (skidDat)
  );

  assign oVld = vldQ;
  assign oRdy = rdyQ;

endmodule

// File: tb/tb_zion_bc_skid_buffer.sv
// Directed and randomized checks of the skid buffer at 32-bit and 16-bit output widths.
module tb_zion_bc_skid_buffer;

  logic        clk;
  logic        rst;
  logic        iClr;
  logic        iVld;
  logic [31:0] iDat;
  logic        iRdy;
  logic        oRdy, oVld;
  logic [31:0] oDat;
  logic        oRdy16, oVld16;
  logic [15:0] oDat16;

  int nVec;
  int nFail;

  zion_bc_skid_buffer dut (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iVld (iVld),
    .iDat (iDat),
    .oRdy (oRdy),
    .oVld (oVld),
    .oDat (oDat),
    .iRdy (iRdy)
  );

  zion_bc_skid_buffer #(
    .WIDTH_IN  (32),
    .WIDTH_OUT (16)
  ) dut16 (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iVld (iVld),
    .iDat (iDat),
    .oRdy (oRdy16),
    .oVld (oVld16),
    .oDat (oDat16),
    .iRdy (iRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      nVec++;
      if (oVld !== 1'b0) begin nFail++; $display("FAIL reset_vld got %0b want 0", oVld); end
      nVec++;
      if (oRdy !== 1'b0) begin nFail++; $display("FAIL reset_rdy got %0b want 0", oRdy); end
      nVec++;
      if (oDat !== 32'h1) begin nFail++; $display("FAIL reset_dat got %h want 00000001", oDat); end
    end
    nVec++;
    if (oDat16 !== 16'h1) begin nFail++; $display("FAIL reset_dat16 got %h want 0001", oDat16); end
    rst = 1'b0;
    step();
    nVec++;
    if (oRdy !== 1'b1) begin nFail++; $display("FAIL release_rdy got %0b want 1", oRdy); end
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL release_vld got %0b want 0", oVld); end
  endtask

  task automatic test_streaming();
    iRdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iVld = 1'b1; iDat = i;
      step();
      nVec++;
      if (oDat !== i) begin nFail++; $display("FAIL stream_dat%0d got %h want %h", i, oDat, i); end
      nVec++;
      if (oVld !== 1'b1) begin nFail++; $display("FAIL stream_vld%0d got %0b want 1", i, oVld); end
      nVec++;
      if (oRdy !== 1'b1) begin nFail++; $display("FAIL stream_rdy%0d got %0b want 1", i, oRdy); end
    end
    iVld = 1'b0;
    step();
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL drain_vld got %0b want 0", oVld); end
    nVec++;
    if (oDat !== 32'h4) begin nFail++; $display("FAIL empty_hold_dat got %h want 00000004", oDat); end
  endtask

  task automatic test_back_pressure();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'hA5;
    step();
    nVec++;
    if (oRdy !== 1'b1) begin nFail++; $display("FAIL bp_one_rdy got %0b want 1", oRdy); end
    iDat = 32'h5A;
    step();
    nVec++;
    if (oRdy !== 1'b0) begin nFail++; $display("FAIL bp_full_rdy got %0b want 0", oRdy); end
    nVec++;
    if (oDat !== 32'hA5) begin nFail++; $display("FAIL bp_full_dat got %h want 000000a5", oDat); end
    iVld = 1'b0; iRdy = 1'b1;
    step();
    nVec++;
    if (oDat !== 32'h5A) begin nFail++; $display("FAIL bp_pop1_dat got %h want 0000005a", oDat); end
    nVec++;
    if (oRdy !== 1'b1) begin nFail++; $display("FAIL bp_pop1_rdy got %0b want 1", oRdy); end
    nVec++;
    if (oVld !== 1'b1) begin nFail++; $display("FAIL bp_pop1_vld got %0b want 1", oVld); end
    step();
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL bp_pop2_vld got %0b want 0", oVld); end
  endtask

  task automatic test_clear_full();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'h11;
    step();
    iDat = 32'h22;
    step();
    nVec++;
    if (oRdy !== 1'b0) begin nFail++; $display("FAIL clr_pre_rdy got %0b want 0", oRdy); end
    iClr = 1'b1; iDat = 32'hFF;
    step();
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL clr_vld got %0b want 0", oVld); end
    nVec++;
    if (oDat !== 32'h1) begin nFail++; $display("FAIL clr_dat got %h want 00000001", oDat); end
    nVec++;
    if (oRdy !== 1'b1) begin nFail++; $display("FAIL clr_rdy got %0b want 1", oRdy); end
    iClr = 1'b0; iVld = 1'b0;
    step();
    nVec++;
    if (oDat !== 32'h1) begin nFail++; $display("FAIL clr_after_dat got %h want 00000001", oDat); end
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL clr_after_vld got %0b want 0", oVld); end
  endtask

  task automatic test_mid_reset();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'h33;
    step();
    step();
    rst = 1'b1;
    step();
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL mrst_vld got %0b want 0", oVld); end
    nVec++;
    if (oRdy !== 1'b0) begin nFail++; $display("FAIL mrst_rdy got %0b want 0", oRdy); end
    nVec++;
    if (oDat !== 32'h1) begin nFail++; $display("FAIL mrst_dat got %h want 00000001", oDat); end
    rst = 1'b0; iDat = 32'h44;
    step();
    nVec++;
    if (oVld !== 1'b0) begin nFail++; $display("FAIL mrst_ignore_vld got %0b want 0", oVld); end
    nVec++;
    if (oRdy !== 1'b1) begin nFail++; $display("FAIL mrst_rel_rdy got %0b want 1", oRdy); end
    iVld = 1'b0;
    step();
  endtask

  task automatic test_truncate();
    iRdy = 1'b1; iVld = 1'b1; iDat = 32'h1234ABCD;
    step();
    nVec++;
    if (oDat16 !== 16'hABCD) begin nFail++; $display("FAIL trunc_dat16 got %h want abcd", oDat16); end
    nVec++;
    if (oDat !== 32'h1234ABCD) begin nFail++; $display("FAIL trunc_dat32 got %h want 1234abcd", oDat); end
    iVld = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic        rdyExp;
    logic [31:0] expMain;
    logic        acc, pp;
    rdyExp = 1'b0;
    expMain = 32'h1;
    for (int c = 0; c < 10000; c++) begin
      rst  = (c == 0) || (c == 5000);
      iClr = ($urandom_range(0, 63) == 0);
      iVld = $urandom_range(0, 1) == 1;
      iRdy = $urandom_range(0, 1) == 1;
      iDat = $urandom;
      if (rst) begin
        q.delete();
        rdyExp  = 1'b0;
        expMain = 32'h1;
      end else begin
        acc = iVld && rdyExp;
        pp  = iRdy && (q.size() > 0);
        if (iClr) begin
          q.delete();
          rdyExp  = 1'b1;
          expMain = 32'h1;
        end else begin
          if (pp) void'(q.pop_front());
          if (acc) q.push_back(iDat);
          rdyExp = (q.size() < 2);
          if (q.size() > 0) expMain = q[0];
        end
      end
      step();
      nVec++;
      if (oVld !== (q.size() > 0) || oVld16 !== (q.size() > 0)) begin
        nFail++;
        $display("FAIL rnd_vld c=%0d got %0b/%0b want %0b", c, oVld, oVld16, q.size() > 0);
      end
      nVec++;
      if (oRdy !== rdyExp || oRdy16 !== rdyExp) begin
        nFail++;
        $display("FAIL rnd_rdy c=%0d got %0b/%0b want %0b", c, oRdy, oRdy16, rdyExp);
      end
      nVec++;
      if (oDat !== expMain) begin
        nFail++;
        $display("FAIL rnd_dat c=%0d got %h want %h", c, oDat, expMain);
      end
      nVec++;
      if (oDat16 !== expMain[15:0]) begin
        nFail++;
        $display("FAIL rnd_dat16 c=%0d got %h want %h", c, oDat16, expMain[15:0]);
      end
    end
    rst = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0;
  endtask

  initial begin
    nVec  = 0;
    nFail = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_clear_full();
    test_mid_reset();
    test_truncate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
